// File: rtl/mont_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mont_sched_pkg
// Description : Shared types and constants for the Montgomery core scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_sched_pkg;

  localparam int WORD_SIZE_DEF = 64;
  localparam int NUM_WORDS_DEF = 1024 / WORD_SIZE_DEF;
  localparam int CNT_W         = $clog2(2 * NUM_WORDS_DEF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mont_operand_buf.sv
`default_nettype none
// ============================================================================
// Module      : mont_operand_buf
// Description : Operand register file, synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_operand_buf
  import mont_sched_pkg::*;
#(
  parameter int DEPTH = 2 * NUM_WORDS_DEF,
  parameter int WIDTH = WORD_SIZE_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mont_core_sched.sv
`default_nettype none
// ============================================================================
// Module      : mont_core_sched
// Description : Round-robin scheduler sharing one Montgomery multiplier core
//               between two requesters; buffers 32 operand words and streams
//               them gap-free to the core. Optional WAIT timeout is compiled
//               in with MONT_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_core_sched
  import mont_sched_pkg::*;
#(
  parameter int INPUT_SIZE     = 1024,
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  output logic [1:0]           gnt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_word,
  output logic                 core_reset,
  output logic [WORD_SIZE-1:0] core_bus,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 op_done,
  output logic                 op_id,
  output logic                 op_err
);

  localparam int c_num_words = INPUT_SIZE / WORD_SIZE;
  localparam int c_depth     = 2 * c_num_words;
  localparam int c_cnt_w     = $clog2(c_depth);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_depth - 1);

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]           r_gnt, w_gnt_nxt;
  logic                 r_last_grant, w_last_grant_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_accept;
  logic                 w_timeout;
  logic [WORD_SIZE-1:0] w_rdata;

  assign w_accept = (r_state == S_LOAD) && in_valid;

  mont_operand_buf #(
    .DEPTH (c_depth),
    .WIDTH (WORD_SIZE),
    .AW    (c_cnt_w)
  ) u_buf (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_cnt),
    .wdata (in_word),
    .raddr (r_cnt),
    .rdata (w_rdata)
  );

`ifdef MONT_SCHED_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_to_w-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_to_w'(TIMEOUT_CYCLES)) begin
      r_wait_cnt <= r_wait_cnt + c_to_w'(1);
    end
  end

  // Fires on the last permitted WAIT cycle so WAIT lasts exactly TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == c_to_w'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_gnt        <= 2'b00;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_gnt_nxt        = r_gnt;
    w_last_grant_nxt = r_last_grant;
    w_err_nxt        = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          // On a tie the requester that was not served last wins.
          if (req == 2'b11) begin
            w_gnt_nxt = r_last_grant ? 2'b01 : 2'b10;
          end else begin
            w_gnt_nxt = req;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (r_cnt == c_last) begin
            w_state_nxt = S_STREAM;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      S_STREAM: begin
        if (r_cnt == c_last) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      S_WAIT: begin
        if (core_done) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt      = S_IDLE;
        w_last_grant_nxt = r_gnt[1];
        w_gnt_nxt        = 2'b00;
        w_err_nxt        = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  assign gnt        = r_gnt;
  assign in_ready   = (r_state == S_LOAD);
  assign core_reset = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign core_bus   = (r_state == S_STREAM) ? w_rdata : '0;
  assign busy       = (r_state != S_IDLE);
  assign op_done    = (r_state == S_DONE);
  assign op_id      = r_gnt[1];
  assign op_err     = r_err;

endmodule
`default_nettype wire
